// File: rtl/ram_program_loader_pkg.sv
// ram_program_loader_pkg
//  Shared definitions for the mainRAM program loader: FSM state encoding,
//  frame geometry constants and the header capacity check.
package ram_program_loader_pkg;

  // Loader FSM states. IDLE is the reset state; DONE is the only state in
  // which the CPU is released from reset.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Word-count header is 16 bits, sent low byte first.
  localparam int HDR_WIDTH  = 16;
  // mainRAM words are 32 bits, assembled from 4 little-endian byte lanes.
  localparam int WORD_WIDTH = 32;
  localparam int LANES      = 4;

  // True when a header word count cannot fit into a RAM of 2**aw words.
  function automatic logic exceeds_capacity(input logic [HDR_WIDTH-1:0] n,
                                            input int aw);
    return 32'(n) > (32'd1 << aw);
  endfunction

endpackage

// File: rtl/ram_program_loader_byte_packer.sv
// byte_packer
//  Collects bytes into a 32-bit little-endian word. Each insert writes the
//  byte into lane idx and advances idx (0..3, wrapping). The word output
//  already contains the byte being inserted this cycle, so the caller can
//  capture a complete word on the same edge that accepts the 4th byte.
// Ports
//  clk, rst   clock, asynchronous active-high reset
//  clear      synchronous clear of lanes and lane index
//  insert     place in_byte into the current lane this cycle
//  in_byte    byte to insert
//  idx        current lane index
//  word       assembled word (including the byte inserted this cycle)
//  word_full  high when this insert completes a word (idx == 3)
module byte_packer
  import ram_program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  insert,
  input  logic [7:0]            in_byte,
  output logic [1:0]            idx,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_full
);

  logic [1:0] idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= 2'd0;
    end else if (clear) begin
      idx_reg <= 2'd0;
    end else if (insert) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] lane_reg;
      logic       hit;

      assign hit = insert && (idx_reg == 2'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= 8'd0;
        end else if (clear) begin
          lane_reg <= 8'd0;
        end else if (hit) begin
          lane_reg <= in_byte;
        end
      end

      // Bypass so the lane being written is visible in the same cycle.
      assign word[8*gi +: 8] = hit ? in_byte : lane_reg;
    end
  endgenerate

  assign idx       = idx_reg;
  assign word_full = insert && (idx_reg == 2'd3);

endmodule

// File: rtl/ram_program_loader.sv
// ram_program_loader
//  Writer side of mainRAM. Receives a byte stream framed as a 16-bit word
//  count N (low byte first) followed by 4*N data bytes, packs them into
//  32-bit little-endian words and writes them to consecutive addresses
//  starting at 0. The CPU is held in reset until a load completes.
// Ports
//  clk, rst   clock, asynchronous active-high reset
//  start      one-cycle pulse, begins a load from IDLE/DONE/ERR
//  in_byte    stream byte; in_valid qualifies it, in_ready accepts it
//  wEnable    mainRAM write strobe (one cycle per word)
//  WSelect    mainRAM write address
//  writeDB    mainRAM write data
//  cpu_hold   CPU reset, low only in DONE
//  busy       load in progress (header, data or write)
//  done, err  load finished / header word count too large for the RAM
module ram_program_loader
  import ram_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wEnable,
  output logic [ADDR_WIDTH-1:0] WSelect,
  output logic [WORD_WIDTH-1:0] writeDB,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t                  state_reg, state_next;
  logic [HDR_WIDTH-1:0]    len_reg,   len_next;
  // One bit wider than the header so a full 2**16-word count never wraps.
  logic [HDR_WIDTH:0]      cnt_reg,   cnt_next;
  logic [ADDR_WIDTH-1:0]   wsel_reg,  wsel_next;
  logic [WORD_WIDTH-1:0]   wdata_reg, wdata_next;

  logic                    transfer;
  logic [HDR_WIDTH-1:0]    hdr_n;
  logic [HDR_WIDTH:0]      cnt_inc;
  logic                    pack_clear;
  logic                    pack_insert;
  logic [1:0]              pack_idx;
  logic [WORD_WIDTH-1:0]   pack_word;
  logic                    pack_full;

  assign transfer = in_valid && in_ready;
  assign hdr_n    = {in_byte, len_reg[7:0]};
  assign cnt_inc  = cnt_reg + 1'b1;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .insert    (pack_insert),
    .in_byte   (in_byte),
    .idx       (pack_idx),
    .word      (pack_word),
    .word_full (pack_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      wsel_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      wsel_reg  <= wsel_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    wsel_next   = wsel_reg;
    wdata_next  = wdata_reg;
    pack_clear  = 1'b0;
    pack_insert = 1'b0;

    unique case (state_reg)
      // Every load, including a reload from DONE or ERR, restarts at
      // address 0 with an empty packer.
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next = ST_HDR_LO;
          wsel_next  = '0;
          cnt_next   = '0;
          pack_clear = 1'b1;
        end
      end

      ST_HDR_LO: begin
        if (transfer) begin
          len_next   = {len_reg[15:8], in_byte};
          state_next = ST_HDR_HI;
        end
      end

      ST_HDR_HI: begin
        if (transfer) begin
          len_next = hdr_n;
          if (hdr_n == '0) begin
            state_next = ST_DONE;
          end else if (exceeds_capacity(hdr_n, ADDR_WIDTH)) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (transfer) begin
          pack_insert = 1'b1;
          if (pack_full) begin
            wdata_next = pack_word;
            state_next = ST_WRITE;
          end
        end
      end

      // The strobe is decoded from this state; the address advances on
      // the way out so it wraps to 0 only after a full-capacity image.
      ST_WRITE: begin
        cnt_next  = cnt_inc;
        wsel_next = wsel_reg + 1'b1;
        if (cnt_inc == {1'b0, len_reg}) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_DATA;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // All control outputs decode directly from the registered state.
  assign in_ready = (state_reg == ST_HDR_LO) || (state_reg == ST_HDR_HI) ||
                    (state_reg == ST_DATA);
  assign wEnable  = (state_reg == ST_WRITE);
  assign busy     = in_ready || wEnable;
  assign done     = (state_reg == ST_DONE);
  assign err      = (state_reg == ST_ERR);
  assign cpu_hold = (state_reg != ST_DONE);
  assign WSelect  = wsel_reg;
  assign writeDB  = wdata_reg;

endmodule

// File: tb/tb_ram_program_loader.sv
// tb_ram_program_loader
//  Self-checking bench for ram_program_loader. A monitor acts as mainRAM and
//  scores every write against an expected-write queue produced by a frame
//  model (header decode + little-endian word assembly over a byte list).
module tb_ram_program_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    int          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          wEnable;
  logic [AW-1:0] WSelect;
  logic [31:0]   writeDB;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  bit prev_wen = 1'b0;
  logic [31:0] mem [DEPTH];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  ram_program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wEnable  (wEnable),
    .WSelect  (WSelect),
    .writeDB  (writeDB),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // mainRAM stand-in plus write scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (wEnable) begin
      wr_t e;
      writes_seen++;
      mem[WSelect] = writeDB;
      check("wen_one_cycle", prev_wen, 1'b0);
      check("write_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("waddr", WSelect, e.addr);
        check("wdata", writeDB, e.data);
      end
    end
    prev_wen = wEnable;
  end

  // Frame model: decode N, classify, and list expected writes.
  task automatic model_frame(input byte_q_t fb, output bit e_done, output bit e_err,
                             output int e_writes, output logic [AW-1:0] e_wsel);
    int n;
    wr_t w;
    n = int'(fb[0]) + 256 * int'(fb[1]);
    e_done = 1'b0; e_err = 1'b0; e_writes = 0; e_wsel = '0;
    exp_q.delete();
    if (n == 0) begin
      e_done = 1'b1;
    end else if (n > DEPTH) begin
      e_err = 1'b1;
    end else begin
      e_done = 1'b1;
      e_writes = n;
      e_wsel = AW'(n % DEPTH);
      for (int k = 0; k < n; k++) begin
        w.addr = AW'(k % DEPTH);
        w.data = {fb[2+4*k+3], fb[2+4*k+2], fb[2+4*k+1], fb[2+4*k]};
        exp_q.push_back(w);
      end
    end
  endtask

  function automatic byte_q_t make_frame(input logic [15:0] n);
    byte_q_t fb;
    fb.push_back(n[7:0]);
    fb.push_back(n[15:8]);
    if (n != 0 && int'(n) <= DEPTH)
      for (int i = 0; i < 4 * int'(n); i++) fb.push_back(8'($urandom));
    return fb;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // gap: 0 = back-to-back, 1 = one idle cycle per byte, 2 = random idle 0..3
  task automatic send_byte(input logic [7:0] b, input int gap);
    int idle;
    int budget;
    idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk); in_valid = 1'b0; in_byte = 8'($urandom);
    end
    @(negedge clk); in_valid = 1'b1; in_byte = b;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk); budget++;
    end
    if (budget >= 50) check("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int budget = 0;
    while (!(done || err) && budget < 50) begin
      @(negedge clk); budget++;
    end
    check("frame_end", done || err, 1'b1);
  endtask

  task automatic run_frame(input string tag, input byte_q_t fb, input int gap);
    bit e_done, e_err;
    int e_writes;
    logic [AW-1:0] e_wsel;
    model_frame(fb, e_done, e_err, e_writes, e_wsel);
    writes_seen = 0;
    pulse_start();
    foreach (fb[i]) send_byte(fb[i], gap);
    wait_end();
    @(negedge clk);
    check({tag, "_done"}, done, e_done);
    check({tag, "_err"}, err, e_err);
    check({tag, "_cpu_hold"}, cpu_hold, !e_done);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_wsel"}, WSelect, e_wsel);
    check({tag, "_writes"}, writes_seen, e_writes);
    check({tag, "_pending"}, exp_q.size(), 0);
    $display("frame %s n=%0d gap=%0d writes=%0d done=%0b err=%0b", tag,
             int'(fb[0]) + 256 * int'(fb[1]), gap, writes_seen, done, err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    byte_q_t fb;
    bit e_done, e_err;
    int e_writes;
    logic [AW-1:0] e_wsel;
    logic [31:0] w_first;

    vecs[0] = '{n: 16'd2,      gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2};
    vecs[1] = '{n: 16'd0,      gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0};
    vecs[2] = '{n: 16'd257,    gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[3] = '{n: 16'd1,      gap: 2, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vecs[4] = '{n: 16'd256,    gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 256};
    vecs[5] = '{n: 16'h1000,   gap: 1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[6] = '{n: 16'd3,      gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 3};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wen", wEnable, 1'b0);
    check("rst_wsel", WSelect, '0);
    check("rst_wdata", writeDB, 32'h0);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // start together with a valid byte in IDLE: the byte must not be taken,
    // otherwise the header would decode as 0x0155 and end in ERR.
    fb = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model_frame(fb, e_done, e_err, e_writes, e_wsel);
    writes_seen = 0;
    @(negedge clk); start = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
    check("idle_in_ready", in_ready, 1'b0);
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    foreach (fb[i]) send_byte(fb[i], 0);
    wait_end();
    check("idle_start_done", done, 1'b1);
    check("idle_start_word", mem[0], 32'h4433_2211);

    // Reference image: two words with known contents.
    fb = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'hAD, 8'hDE};
    run_frame("image", fb, 0);
    check("image_mem0", mem[0], 32'hA5A5_FF00);
    check("image_mem1", mem[1], 32'hDEAD_0000);

    // Same image with in_valid toggling between bytes.
    mem[0] = 32'h0; mem[1] = 32'h0;
    run_frame("toggle", fb, 1);
    check("toggle_mem0", mem[0], 32'hA5A5_FF00);
    check("toggle_mem1", mem[1], 32'hDEAD_0000);

    // Zero-length header: DONE right after the high header byte.
    writes_seen = 0;
    exp_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zero_done_now", done, 1'b1);
    check("zero_cpu_hold", cpu_hold, 1'b0);
    check("zero_writes", writes_seen, 0);

    // Oversize header then recovery with a 1-word frame.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("ovf_err", err, 1'b1);
    check("ovf_cpu_hold", cpu_hold, 1'b1);
    check("ovf_in_ready", in_ready, 1'b0);
    fb = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame("recover", fb, 0);
    check("recover_mem0", mem[0], 32'hDEAD_BEEF);

    // Stall mid-word, and a start pulse while busy that must be ignored.
    fb = make_frame(16'd2);
    model_frame(fb, e_done, e_err, e_writes, e_wsel);
    writes_seen = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(fb[i], 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("stall_busy", busy, 1'b1);
      check("stall_in_ready", in_ready, 1'b1);
      check("stall_wen", wEnable, 1'b0);
    end
    pulse_start();
    for (int i = 4; i < fb.size(); i++) send_byte(fb[i], 0);
    wait_end();
    check("busy_start_done", done, 1'b1);
    check("busy_start_writes", writes_seen, 2);
    check("busy_start_pending", exp_q.size(), 0);

    // Table-driven frames.
    foreach (vecs[v]) begin
      fb = make_frame(vecs[v].n);
      run_frame($sformatf("vec%0d", v), fb, vecs[v].gap);
      check("tbl_done", done, vecs[v].exp_done);
      check("tbl_err", err, vecs[v].exp_err);
      check("tbl_writes", writes_seen, vecs[v].exp_writes);
    end

    // Randomized frames, including occasional oversize headers.
    for (int r = 0; r < 8; r++) begin
      logic [15:0] n;
      n = (r == 7) ? 16'($urandom_range(DEPTH + 1, 16'hFFFF))
                   : 16'($urandom_range(1, 24));
      fb = make_frame(n);
      run_frame($sformatf("rnd%0d", r), fb, 2);
    end

    // Three-word program image, then CPU release from DONE.
    fb = make_frame(16'd3);
    w_first = {fb[5], fb[4], fb[3], fb[2]};
    run_frame("program", fb, 0);
    check("program_mem0", mem[0], w_first);
    check("program_release", cpu_hold, 1'b0);

    // Asynchronous reset in the middle of a load.
    fb = make_frame(16'd3);
    model_frame(fb, e_done, e_err, e_writes, e_wsel);
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(fb[i], 0);
    repeat (2) @(negedge clk);
    check("mid_wsel_before", WSelect, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cpu_hold", cpu_hold, 1'b1);
    check("mid_rst_wen", wEnable, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_wsel", WSelect, '0);
    check("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    check("mid_rst_ram_kept", mem[0], {fb[5], fb[4], fb[3], fb[2]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
